// File: rtl/eth_pcs_pkg.sv
// Shared PCS definitions: K28.5 comma codes, word-aligner FSM states and the
// comma-detect result payload.
package eth_pcs_pkg;

  localparam int unsigned SYM_W   = 10;
  localparam int unsigned TAIL_W  = 9;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  typedef struct packed {
    logic               hit;
    logic [PHASE_W-1:0] phase;
  } comma_det_t;

  function automatic logic is_k28_5(input logic [SYM_W-1:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.5 search over the alignment window; reports whether any
// comma is present and the bit phase of the lowest-index match.
module comma_detect
  import eth_pcs_pkg::*;
#(
  parameter int unsigned SYMBOLS = 2
) (
  input  logic [SYM_W*SYMBOLS+TAIL_W-1:0] window_i,
  output comma_det_t                      det_o
);

  localparam int unsigned W = SYM_W * SYMBOLS;

  // Scan high to low so the lowest matching index is the one that sticks.
  always_comb begin
    det_o = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (is_k28_5(window_i[i +: SYM_W])) begin
        det_o.hit   = 1'b1;
        det_o.phase = PHASE_W'(i % int'(SYM_W));
      end
    end
  end

endmodule

// File: rtl/word_aligner.sv
// 8b/10b word aligner: finds the K28.5 bit phase, locks after repeated
// agreement, and emits symbol-aligned words. Define WORD_ALIGNER_STATS_EN to
// add the saturating realign_count output.
module word_aligner
  import eth_pcs_pkg::*;
#(
  parameter int unsigned SYMBOLS    = 2,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SYM_W*SYMBOLS-1:0]   in_data,
  output logic                       out_valid,
  output logic [SYM_W*SYMBOLS-1:0]   out_data,
  output logic [SYMBOLS-1:0]         out_comma,
  output logic                       locked,
  output logic [PHASE_W-1:0]         phase
`ifdef WORD_ALIGNER_STATS_EN
  ,
  output logic [15:0]                realign_count
`endif
);

  localparam int unsigned W     = SYM_W * SYMBOLS;
  localparam int unsigned WIN_W = W + TAIL_W;

  align_state_e        state_q, state_d;
  logic [PHASE_W-1:0]  cand_q, cand_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [TAIL_W-1:0]   last_q, last_d;
  logic                out_valid_q;
  logic [W-1:0]        out_data_q;
  logic [SYMBOLS-1:0]  out_comma_q;
  logic                locked_q;
`ifdef WORD_ALIGNER_STATS_EN
  logic [15:0]         realign_q, realign_d;
`endif

  logic [WIN_W-1:0]    window;
  logic [W-1:0]        aligned_c;
  logic [SYMBOLS-1:0]  comma_c;
  comma_det_t          det;

  // Only the low 9 bits of the previous word can reach a 10-bit match or a
  // phase-0..9 output slice, so that is all that is kept.
  assign window = {last_q, in_data};

  comma_detect #(
    .SYMBOLS (SYMBOLS)
  ) u_comma_detect (
    .window_i (window),
    .det_o    (det)
  );

  assign aligned_c = W'(window >> phase_q);

  always_comb begin
    comma_c = '0;
    for (int k = 0; k < int'(SYMBOLS); k++) begin
      comma_c[k] = is_k28_5(aligned_c[k*int'(SYM_W) +: SYM_W]);
    end
  end

  // Next-state: hunt / verify / locked; everything holds while in_valid is low.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    last_d  = last_q;
`ifdef WORD_ALIGNER_STATS_EN
    realign_d = realign_q;
`endif
    if (in_valid) begin
      last_d = in_data[TAIL_W-1:0];
      if (det.hit) begin
        case (state_q)
          ST_HUNT: begin
            cand_d = det.phase;
            if (LOCK_COUNT == 1) begin
              state_d = ST_LOCKED;
              phase_d = det.phase;
              cnt_d   = '0;
            end else begin
              state_d = ST_VERIFY;
              cnt_d   = CNT_W'(1);
            end
          end
          ST_VERIFY: begin
            if (det.phase == cand_q) begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_d == CNT_W'(LOCK_COUNT)) begin
                state_d = ST_LOCKED;
                phase_d = cand_q;
                cnt_d   = '0;
              end
            end else begin
              cand_d = det.phase;
              cnt_d  = CNT_W'(1);
            end
          end
          ST_LOCKED: begin
            if (det.phase == phase_q) begin
              err_d = '0;
            end else begin
              err_d = err_q + CNT_W'(1);
              if (err_d == CNT_W'(LOSS_COUNT)) begin
                state_d = ST_HUNT;
                err_d   = '0;
                cnt_d   = '0;
`ifdef WORD_ALIGNER_STATS_EN
                if (realign_q != 16'hFFFF) begin
                  realign_d = realign_q + 16'd1;
                end
`endif
              end
            end
          end
          default: begin
            state_d = ST_HUNT;
            cnt_d   = '0;
            err_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      cand_q      <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_comma_q <= '0;
      locked_q    <= 1'b0;
`ifdef WORD_ALIGNER_STATS_EN
      realign_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      last_q      <= last_d;
      out_valid_q <= in_valid;
      locked_q    <= (state_d == ST_LOCKED);
      if (in_valid) begin
        out_data_q  <= aligned_c;
        out_comma_q <= comma_c;
      end
`ifdef WORD_ALIGNER_STATS_EN
      realign_q   <= realign_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_comma = out_comma_q;
  assign locked    = locked_q;
  assign phase     = phase_q;
`ifdef WORD_ALIGNER_STATS_EN
  assign realign_count = realign_q;
`endif

endmodule
